// File: rtl/axis_cp_fifo_if.sv
// AXI4-Stream bundle used on both sides of axis_cp_fifo.
// The master drives payload and valid, and the slave drives ready.
interface axis_cp_fifo_if;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_cp_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with cut-through or store-and-forward release.
// level and pkt_count report the stored words and the complete packets held.
module axis_cp_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PKT_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_cp_fifo_if.slave          s_axis,
    axis_cp_fifo_if.master         m_axis,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] pkt_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] pkt_q, pkt_d;
    logic          s_ready_q, s_ready_d;

    logic          full;
    logic          empty;
    logic          m_valid;
    logic          wr_en;
    logic          rd_en;
    logic          pkt_inc;
    logic          pkt_dec;

    always_comb begin
        head  = mem_q[rd_ptr_q];
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);

        // Releasing on full lets a packet longer than the FIFO drain in store-and-forward mode.
        if (PKT_MODE == 0) begin
            m_valid = !empty;
        end else begin
            m_valid = !empty && ((pkt_q != '0) || full);
        end

        wr_en   = s_axis.tvalid && s_ready_q;
        rd_en   = m_valid && m_axis.tready;
        pkt_inc = wr_en && s_axis.tlast;
        pkt_dec = rd_en && head.last;

        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + CNT_ONE;
            2'b01:   level_d = level_q - CNT_ONE;
            default: level_d = level_q;
        endcase

        pkt_d = pkt_q;
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + CNT_ONE;
            2'b01:   pkt_d = pkt_q - CNT_ONE;
            default: pkt_d = pkt_q;
        endcase

        // Ready comes from the next-state level, so it is a flop output that never allows overflow.
        s_ready_d = (level_d != FULL_LVL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_q     <= pkt_d;
            s_ready_q <= s_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
        end
    end

    always_comb begin
        s_axis.tready = s_ready_q;
        m_axis.tvalid = m_valid;
        m_axis.tdata  = m_valid ? head.data : '0;
        m_axis.tkeep  = m_valid ? head.keep : '0;
        m_axis.tlast  = m_valid ? head.last : 1'b0;
        level         = level_q;
        pkt_count     = pkt_q;
    end

endmodule

// File: tb/tb_axis_cp_fifo.sv
// Bench for axis_cp_fifo: a cut-through instance (0) and a store-and-forward instance (1),
// both checked every cycle against a queue model, plus directed literal checks.
module tb_axis_cp_fifo;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_cp_fifo_if s0 ();
    axis_cp_fifo_if m0 ();
    axis_cp_fifo_if s1 ();
    axis_cp_fifo_if m1 ();

    logic       in_valid [2] = '{1'b0, 1'b0};
    ent_t       in_ent   [2] = '{'0, '0};
    logic       m_rdy    [2] = '{1'b0, 1'b0};
    logic       o_rdy    [2];
    logic       o_vld    [2];
    ent_t       o_ent    [2];
    logic [4:0] o_lvl    [2];
    logic [4:0] o_pkt    [2];

    assign s0.tvalid = in_valid[0];
    assign s0.tdata  = in_ent[0].d;
    assign s0.tkeep  = in_ent[0].k;
    assign s0.tlast  = in_ent[0].l;
    assign m0.tready = m_rdy[0];
    assign s1.tvalid = in_valid[1];
    assign s1.tdata  = in_ent[1].d;
    assign s1.tkeep  = in_ent[1].k;
    assign s1.tlast  = in_ent[1].l;
    assign m1.tready = m_rdy[1];

    assign o_rdy[0] = s0.tready;
    assign o_vld[0] = m0.tvalid;
    assign o_ent[0] = {m0.tdata, m0.tkeep, m0.tlast};
    assign o_rdy[1] = s1.tready;
    assign o_vld[1] = m1.tvalid;
    assign o_ent[1] = {m1.tdata, m1.tkeep, m1.tlast};

    axis_cp_fifo #(.DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
        .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
        .level(o_lvl[0]), .pkt_count(o_pkt[0])
    );

    axis_cp_fifo #(.DEPTH(DEPTH), .PKT_MODE(1)) u_sf (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
        .level(o_lvl[1]), .pkt_count(o_pkt[1])
    );

    // Model state: words waiting to be sent, and words the FIFO must hold.
    ent_t        sq [2][$];
    ent_t        mq [2][$];
    bit          exp_rdy  [2] = '{1'b0, 1'b0};
    bit          stalled  [2] = '{1'b0, 1'b0};
    bit          wr_last  [2] = '{1'b0, 1'b0};
    int unsigned vprob    [2] = '{0, 0};
    int unsigned rprob    [2] = '{0, 0};
    ent_t        prev_ent [2];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [144:0] act, input logic [144:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [127:0] d, input logic [15:0] k, input logic l);
        return {d, k, l};
    endfunction

    function automatic ent_t rnd_ent(input logic l);
        return mk({$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()), l);
    endfunction

    function automatic int npk(input int i);
        int n = 0;
        for (int j = 0; j < mq[i].size(); j++) begin
            if (mq[i][j].l) n++;
        end
        return n;
    endfunction

    // Instance 1 stores and forwards: it needs a whole packet held, or a full FIFO.
    function automatic bit exp_vld(input int i);
        if (mq[i].size() == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (npk(i) != 0) || (mq[i].size() == DEPTH);
    endfunction

    always @(posedge clk or negedge rst) begin
        bit v, wr, rd;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                exp_rdy[i] = 1'b0;
                stalled[i] = 1'b0;
                wr_last[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                v  = exp_vld(i);
                wr = in_valid[i] && exp_rdy[i];
                rd = v && m_rdy[i];
                stalled[i] = v && !m_rdy[i];
                wr_last[i] = wr;
                if (rd) void'(mq[i].pop_front());
                if (wr) begin
                    mq[i].push_back(in_ent[i]);
                    void'(sq[i].pop_front());
                end
                exp_rdy[i] = (mq[i].size() != DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        logic [159:0] junk;
        for (int i = 0; i < 2; i++) begin
            if (!rst || sq[i].size() == 0) begin
                in_valid[i] = 1'b0;
            end else if (!(in_valid[i] && !wr_last[i])) begin
                in_valid[i] = ($urandom_range(99) < vprob[i]);
            end
            junk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            in_ent[i] = in_valid[i] ? sq[i][0] : junk[144:0];
            m_rdy[i]  = rst && ($urandom_range(99) < rprob[i]);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d s_tready", i), 145'(o_rdy[i]), 145'(exp_rdy[i]));
                chk($sformatf("dut%0d m_tvalid", i), 145'(o_vld[i]), 145'(exp_vld(i)));
                chk($sformatf("dut%0d level", i), 145'(o_lvl[i]), 145'(mq[i].size()));
                chk($sformatf("dut%0d pkt_count", i), 145'(o_pkt[i]), 145'(npk(i)));
                if (exp_vld(i)) chk($sformatf("dut%0d head word", i), o_ent[i], mq[i][0]);
                if (stalled[i]) chk($sformatf("dut%0d stall hold", i), o_ent[i], prev_ent[i]);
                prev_ent[i] = o_ent[i];
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d s_tready", tag, i), 145'(o_rdy[i]), 145'(0));
            chk($sformatf("%s dut%0d m_tvalid", tag, i), 145'(o_vld[i]), 145'(0));
            chk($sformatf("%s dut%0d level", tag, i), 145'(o_lvl[i]), 145'(0));
            chk($sformatf("%s dut%0d pkt_count", tag, i), 145'(o_pkt[i]), 145'(0));
            chk($sformatf("%s dut%0d m_payload", tag, i), o_ent[i], 145'(0));
        end
    endtask

    task automatic wait_drain(input int i, input int budget);
        int c = 0;
        while ((sq[i].size() != 0 || mq[i].size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk($sformatf("dut%0d drain done", i), 145'(sq[i].size() + mq[i].size()), 145'(0));
    endtask

    task automatic push_pkt(input int i, input int len);
        for (int j = 1; j <= len; j++) sq[i].push_back(rnd_ent(j == len));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int words;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("in reset");
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("dut0 ready after reset", 145'(o_rdy[0]), 145'(1));
        chk("dut1 ready after reset", 145'(o_rdy[1]), 145'(1));

        // Cut-through fill to full, then drain.
        vprob[0] = 100;
        rprob[0] = 0;
        for (int k = 1; k <= 16; k++) sq[0].push_back(mk(128'(k), 16'hFFFF, 1'b0));
        repeat (16) @(posedge clk);
        #1;
        chk("fill level", 145'(o_lvl[0]), 145'(16));
        chk("fill s_tready", 145'(o_rdy[0]), 145'(0));
        chk("fill m_tvalid", 145'(o_vld[0]), 145'(1));
        chk("fill head", o_ent[0], mk(128'(1), 16'hFFFF, 1'b0));
        rprob[0] = 100;
        wait_drain(0, 40);
        chk("drained level", 145'(o_lvl[0]), 145'(0));

        // Store-and-forward: a 3-word packet is held until its last word is in.
        vprob[1] = 100;
        rprob[1] = 0;
        push_pkt(1, 3);
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sf3 level w%0d", n), 145'(o_lvl[1]), 145'(n));
            chk($sformatf("sf3 m_tvalid w%0d", n), 145'(o_vld[1]), 145'(n == 3));
            chk($sformatf("sf3 pkt_count w%0d", n), 145'(o_pkt[1]), 145'(n == 3));
        end
        rprob[1] = 100;
        wait_drain(1, 40);

        // Store-and-forward: a 20-word packet must release on full.
        rprob[1] = 0;
        push_pkt(1, 20);
        c = 0;
        while (mq[1].size() != 16 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("sf20 level", 145'(o_lvl[1]), 145'(16));
        chk("sf20 m_tvalid", 145'(o_vld[1]), 145'(1));
        chk("sf20 pkt_count", 145'(o_pkt[1]), 145'(0));
        rprob[1] = 100;
        wait_drain(1, 100);

        // Back-to-back stream of 100 words.
        vprob[0] = 100;
        rprob[0] = 100;
        for (int k = 0; k < 100; k++) sq[0].push_back(rnd_ent($urandom_range(7) == 0));
        c = 0;
        while ((sq[0].size() != 0 || mq[0].size() != 0) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            if (c <= 100) chk("stream level", 145'(o_lvl[0]), 145'(1));
        end
        chk("stream cycles", 145'(c), 145'(101));

        // Random valid/ready, packets of 1..40 words on both instances.
        for (int i = 0; i < 2; i++) begin
            words = 0;
            while (words < 5000) begin
                c = $urandom_range(40, 1);
                push_pkt(i, c);
                words += c;
            end
            vprob[i] = 50;
            rprob[i] = 50;
        end
        wait_drain(0, 30000);
        wait_drain(1, 30000);

        // Reset in the middle of a packet.
        for (int i = 0; i < 2; i++) begin
            vprob[i] = 100;
            rprob[i] = 0;
            push_pkt(i, 12);
        end
        c = 0;
        while (mq[0].size() != 7 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("pre-reset level", 145'(o_lvl[0]), 145'(7));
        @(negedge clk);
        #2 rst = 1'b0;
        sq[0].delete();
        sq[1].delete();
        #1;
        check_reset("mid-packet reset");
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("dut0 ready after re-reset", 145'(o_rdy[0]), 145'(1));
        chk("dut1 ready after re-reset", 145'(o_rdy[1]), 145'(1));
        for (int i = 0; i < 2; i++) begin
            push_pkt(i, 5);
            rprob[i] = 100;
        end
        wait_drain(0, 60);
        wait_drain(1, 60);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_cp_fifo.md
AXIS_CP_FIFO -- requirements
Module: axis_cp_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 4..256.
REQ-002 Parameter PKT_MODE, default 0; 0 = cut-through, 1 = store-and-forward.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, with no clock required.
REQ-005 s_axis_tdata / s_axis_tkeep / s_axis_tlast / s_axis_tvalid  in  128/16/1/1  input stream from the upstream 16:1 channel mux output.
REQ-006 s_axis_tready  out  1  FIFO can accept a word.
REQ-007 m_axis_tdata / m_axis_tkeep / m_axis_tlast / m_axis_tvalid  out  128/16/1/1  buffered output stream.
REQ-008 m_axis_tready  in  1  downstream accept.
REQ-009 level  out  clog2(DEPTH)+1  number of words stored.
REQ-010 pkt_count  out  clog2(DEPTH)+1  number of stored words with tlast=1 (complete packets held).

Function
REQ-011 A write SHALL occur when s_axis_tvalid && s_axis_tready; a read SHALL occur when m_axis_tvalid && m_axis_tready.
REQ-012 s_axis_tready SHALL be the registered value of (level != DEPTH); it SHALL NOT depend combinationally on m_axis_tready. When full, a same-cycle read SHALL NOT enable a same-cycle write.
REQ-013 Storage SHALL be a circular buffer with write and read pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0 with no gap.
REQ-014 Output SHALL be first-word-fall-through: m_axis_tdata/tkeep/tlast SHALL present the head entry whenever m_axis_tvalid=1, and SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-015 Latency: a word written at edge N SHALL be visible on m_axis at N+1 (PKT_MODE=0) when the FIFO was empty.
REQ-016 PKT_MODE=0: m_axis_tvalid SHALL equal (level != 0).
REQ-017 PKT_MODE=1: m_axis_tvalid SHALL equal (level != 0) && (pkt_count != 0 || level == DEPTH). The full-release term SHALL prevent deadlock on packets longer than DEPTH.
REQ-018 Once m_axis_tvalid rises, it SHALL NOT fall until a read occurs (AXIS rule). An implementation satisfying REQ-016/017 meets this because level and pkt_count only decrease on read.
REQ-019 level SHALL change by +1 on write only, -1 on read only, and 0 on a simultaneous write and read.
REQ-020 pkt_count SHALL increment on a write with tlast=1 and decrement on a read with tlast=1. On a simultaneous write and read of tlast=1 words, it SHALL be unchanged.
REQ-021 tkeep SHALL be stored and forwarded unmodified; the block SHALL NOT interpret, pack, or validate tkeep.
REQ-022 Input words SHALL NOT be dropped, duplicated, or reordered. Output order SHALL equal input order across any number of pointer wraps.

Reset
REQ-023 While rst=0: s_axis_tready=0, m_axis_tvalid=0, level=0, pkt_count=0, pointers=0. m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL be 0.
REQ-024 On the first rising clk after rst returns to 1, s_axis_tready SHALL become 1.
REQ-025 Reset asserted mid-packet or mid-transfer SHALL discard all stored contents. No partial packet SHALL appear after reset.
REQ-026 Memory array contents SHALL require no reset.

Verification
REQ-027 PKT_MODE=0, DEPTH=16: write 0x...01 to 0x...10 with m_axis_tready=0 -> level=16, s_axis_tready=0 on the next cycle; then m_axis_tready=1 -> words 0x01..0x10 out in order, level returns to 0.
REQ-028 PKT_MODE=1: write a 3-word packet with tlast on word 3 -> m_axis_tvalid=0 through word 2, m_axis_tvalid=1 the cycle after word 3 is written, pkt_count=1.
REQ-029 PKT_MODE=1, DEPTH=16: write a 20-word packet -> at level=16 m_axis_tvalid=1 with pkt_count=0; all 20 words are delivered in order, with no deadlock.
REQ-030 Steady stream, both sides valid/ready every cycle for 100 words, random tkeep -> level constant, 1 word per cycle throughput, data and tkeep match, pointers wrap at least 6 times.
REQ-031 Random tvalid/tready at 50% each, 10,000 words, packets of length 1..40 -> scoreboard exact match; pkt_count equals the tlast words present; m_axis outputs stable while stalled.
REQ-032 Assert rst=0 for 1 cycle with level=7 mid-packet -> all outputs go to their reset values immediately; the subsequent new packet is delivered with no residue.
